// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB / CBC-encrypt / CTR stream controller around the
// 128-bit iterative AES encrypt engine (start/ready/valid handshake).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_mode/key/iv/load     configuration; load latches mode, key, IV
//   cfg_err                  one-cycle pulse when a load is rejected
//   busy                     input FIFO non-empty or a block in flight
//   s_valid/ready/data/last  plaintext input stream (buffered)
//   m_valid/ready/data/last  ciphertext output stream
//   eng_start/ready/valid    engine control handshake
//   eng_in/key/out           engine data (eng_in registered)
module aes_mode_ctrl #(
    parameter int IN_DEPTH = 2,
    parameter int CTR_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   cfg_mode,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_load,
    output logic         cfg_err,
    output logic         busy,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_last,
    output logic         eng_start,
    input  logic         eng_ready,
    input  logic         eng_valid,
    output logic [127:0] eng_in,
    output logic [127:0] eng_key,
    input  logic [127:0] eng_out
);

    localparam int AW = $clog2(IN_DEPTH);

    localparam logic [1:0] M_ECB = 2'd0;
    localparam logic [1:0] M_CBC = 2'd1;
    localparam logic [1:0] M_CTR = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

    // Selects the incrementing low part of the counter block.
    localparam logic [127:0] LO_MASK = {128{1'b1}} >> (128 - CTR_W);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [127:0] key_reg;
    logic [127:0] iv_reg;
    logic [127:0] chain;
    logic [127:0] ctr;
    logic [1:0]   mode_reg;
    logic         cfg_ok;

    logic [127:0] p_reg;
    logic         last_reg;

    logic [127:0] fifo_data [IN_DEPTH];
    logic         fifo_last [IN_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         fifo_empty;
    logic         fifo_full;

    logic         push;
    logic         pop;
    logic         cfg_acc;
    logic         done;
    logic         hs;

    logic [127:0] head_data;
    logic         head_last;
    logic [127:0] eng_in_nx;
    logic [127:0] res_nx;
    logic [CTR_W-1:0] ctr_lo;
    logic [127:0] ctr_inc;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign head_data = fifo_data[rd_ptr[AW-1:0]];
    assign head_last = fifo_last[rd_ptr[AW-1:0]];

    assign s_ready = cfg_ok & ~fifo_full;
    assign push    = s_valid & s_ready;

    // A new block only starts once the previous result has left.
    assign pop = (state == IDLE) & ~fifo_empty & eng_ready & ~m_valid;

    assign busy    = ~fifo_empty | (state != IDLE);
    assign cfg_acc = cfg_load & ~busy & ~m_valid & (cfg_mode != M_RSV);
    assign done    = (state == RUN) & eng_valid;
    assign hs      = (state == HOLD) & m_ready;
    assign eng_key = key_reg;

    assign ctr_lo  = ctr[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1};
    assign ctr_inc = (ctr & ~LO_MASK) | 128'(ctr_lo);

    always_comb begin
        eng_in_nx = head_data;
        case (mode_reg)
            M_ECB:   eng_in_nx = head_data;
            M_CBC:   eng_in_nx = head_data ^ chain;
            M_CTR:   eng_in_nx = ctr;
            default: eng_in_nx = head_data;
        endcase
    end

    assign res_nx = (mode_reg == M_CTR) ? (p_reg ^ eng_out) : eng_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_nx = START;
                end
            end
            START: begin
                eng_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                if (eng_valid) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage array needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr[AW-1:0]] <= s_data;
            fifo_last[wr_ptr[AW-1:0]] <= s_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg  <= '0;
            iv_reg   <= '0;
            chain    <= '0;
            ctr      <= '0;
            mode_reg <= M_ECB;
            cfg_ok   <= 1'b0;
            cfg_err  <= 1'b0;
            p_reg    <= '0;
            last_reg <= 1'b0;
            eng_in   <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            cfg_err <= cfg_load & ~cfg_acc;

            if (cfg_acc) begin
                key_reg  <= cfg_key;
                mode_reg <= cfg_mode;
                iv_reg   <= cfg_iv;
                chain    <= cfg_iv;
                ctr      <= cfg_iv;
                cfg_ok   <= 1'b1;
            end

            if (pop) begin
                p_reg    <= head_data;
                last_reg <= head_last;
                eng_in   <= eng_in_nx;
            end

            if (done) begin
                m_data  <= res_nx;
                m_valid <= 1'b1;
                m_last  <= last_reg;
                if (mode_reg == M_CBC) begin
                    chain <= eng_out;
                end
                if (mode_reg == M_CTR) begin
                    ctr <= ctr_inc;
                end
            end

            // End of message: the next one restarts from the IV.
            if (hs) begin
                m_valid <= 1'b0;
                if (m_last) begin
                    chain <= iv_reg;
                    ctr   <= iv_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: directed bench for aes_mode_ctrl with a behavioural
// engine that returns known AES answers for the test vectors.
module tb_aes_mode_ctrl;

    localparam int LAT = 4;

    localparam logic [1:0] M_ECB = 2'd0;
    localparam logic [1:0] M_CBC = 2'd1;
    localparam logic [1:0] M_CTR = 2'd2;
    localparam logic [1:0] M_RSV = 2'd3;

    localparam logic [127:0] K_ECB  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_ECB  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_ECB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_N    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] X1_CBC = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] C1_CBC = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] X2_CBC = 128'hd86421fb9f1a1eda505ee1375746972c;
    localparam logic [127:0] C2_CBC = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CT2    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] O1_CTR = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] O2_CTR = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] C1_CTR = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2_CTR = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] K_BP   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] K_W    = 128'h0000000000000000000000000000beef;
    localparam logic [127:0] IV_W   = 128'h111111112222222233333333ffffffff;
    localparam logic [127:0] IV_W2  = 128'h11111111222222223333333300000000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   cfg_mode = '0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         cfg_load = 1'b0;
    logic         cfg_err;
    logic         busy;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_data;
    logic         m_last;
    logic         eng_start;
    logic         eng_ready;
    logic         eng_valid;
    logic [127:0] eng_in;
    logic [127:0] eng_key;
    logic [127:0] eng_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_dbl = 0;
    int n_viol = 0;
    int n_hold = 0;
    logic [127:0] ein_q [$];

    aes_mode_ctrl #(.IN_DEPTH(2), .CTR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_load(cfg_load), .cfg_err(cfg_err), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .eng_start(eng_start),
        .eng_ready(eng_ready), .eng_valid(eng_valid), .eng_in(eng_in),
        .eng_key(eng_key), .eng_out(eng_out)
    );

    always #5 clk = ~clk;

    // Known AES-128 answers; anything else gets a simple keyed mix.
    function automatic logic [127:0] aes_ref(input logic [127:0] k,
                                             input logic [127:0] x);
        logic [127:0] r;
        r = x ^ k;
        if (k == K_ECB && x == P_ECB) r = C_ECB;
        if (k == K_N && x == X1_CBC) r = C1_CBC;
        if (k == K_N && x == X2_CBC) r = C2_CBC;
        if (k == K_N && x == IV_CTR) r = O1_CTR;
        if (k == K_N && x == CT2) r = O2_CTR;
        return r;
    endfunction

    logic         e_busy;
    int           e_cnt;
    logic [127:0] e_k;
    logic [127:0] e_x;

    assign eng_ready = ~e_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_busy    <= 1'b0;
            e_cnt     <= 0;
            e_k       <= '0;
            e_x       <= '0;
            eng_valid <= 1'b0;
            eng_out   <= '0;
        end else begin
            eng_valid <= 1'b0;
            if (eng_start && !e_busy) begin
                e_busy <= 1'b1;
                e_cnt  <= LAT;
                e_k    <= eng_key;
                e_x    <= eng_in;
            end else if (e_busy) begin
                if (e_cnt == 1) begin
                    e_busy    <= 1'b0;
                    eng_valid <= 1'b1;
                    eng_out   <= aes_ref(e_k, e_x);
                end else begin
                    e_cnt <= e_cnt - 1;
                end
            end
        end
    end

    logic         prev_start = 1'b0;
    logic         hold_p = 1'b0;
    logic [127:0] hold_d = '0;

    always @(posedge clk) begin
        if (rst) begin
            if (eng_start) begin
                n_start <= n_start + 1;
                ein_q.push_back(eng_in);
                if (prev_start) n_dbl <= n_dbl + 1;
                if (m_valid) n_viol <= n_viol + 1;
            end
            if (hold_p && (!m_valid || m_data !== hold_d)) begin
                n_hold <= n_hold + 1;
            end
        end
        prev_start <= eng_start && rst;
        hold_p     <= rst && m_valid && !m_ready;
        hold_d     <= m_data;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ein_at(input int i);
        logic [127:0] v;
        v = 'x;
        if (ein_q.size() > i) v = ein_q[i];
        return v;
    endfunction

    task automatic do_cfg(input logic [1:0] md, input logic [127:0] k,
                          input logic [127:0] iv, output logic err);
        @(negedge clk);
        cfg_mode = md;
        cfg_key  = k;
        cfg_iv   = iv;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        err = cfg_err;
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 128'(s_ready), 128'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_mv();
        int n;
        n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid_wait", 128'(m_valid), 128'd1);
    endtask

    task automatic recv(output logic [127:0] d, output logic l);
        @(negedge clk);
        m_ready = 1'b1;
        wait_mv();
        d = m_data;
        l = m_last;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    logic [127:0] d;
    logic         l;
    logic         err;
    int           s0;
    int           n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_ctl",
            128'({s_ready, busy, m_valid, m_last, eng_start, cfg_err}),
            128'd0);
        chk("rst_m_data", m_data, 128'd0);
        chk("rst_eng_in", eng_in, 128'd0);
        chk("rst_eng_key", eng_key, 128'd0);
        #20;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_cfg_s_ready", 128'(s_ready), 128'd0);

        // ECB, then a reserved-mode load that must not disturb it.
        do_cfg(M_ECB, K_ECB, '0, err);
        chk("ecb_cfg_err", 128'(err), 128'd0);
        chk("ecb_s_ready", 128'(s_ready), 128'd1);
        do_cfg(M_RSV, K_N, IV_CTR, err);
        chk("rsv_cfg_err", 128'(err), 128'd1);
        @(negedge clk);
        chk("cfg_err_pulse", 128'(cfg_err), 128'd0);
        s0 = n_start;
        send(P_ECB, 1'b1);
        recv(d, l);
        chk("ecb_data", d, C_ECB);
        chk("ecb_last", 128'(l), 128'd1);
        repeat (2) @(negedge clk);
        chk("ecb_starts", 128'(n_start - s0), 128'd1);
        chk("idle_busy", 128'(busy), 128'd0);

        // CBC two-block message, then a fresh message from the IV.
        do_cfg(M_CBC, K_N, IV_CBC, err);
        chk("cbc_cfg_err", 128'(err), 128'd0);
        ein_q.delete();
        send(P1, 1'b0);
        send(P2, 1'b1);
        recv(d, l);
        chk("cbc_c1", d, C1_CBC);
        chk("cbc_c1_last", 128'(l), 128'd0);
        recv(d, l);
        chk("cbc_c2", d, C2_CBC);
        chk("cbc_c2_last", 128'(l), 128'd1);
        chk("cbc_ein2", ein_at(1), X2_CBC);
        send(P1, 1'b1);
        recv(d, l);
        chk("cbc_restart", d, C1_CBC);

        // CTR two-block message.
        do_cfg(M_CTR, K_N, IV_CTR, err);
        ein_q.delete();
        send(P1, 1'b0);
        send(P2, 1'b1);
        recv(d, l);
        chk("ctr_c1", d, C1_CTR);
        recv(d, l);
        chk("ctr_c2", d, C2_CTR);
        chk("ctr_ein1", ein_at(0), IV_CTR);
        chk("ctr_ein2", ein_at(1), CT2);

        // CTR low-word wrap; upper 96 bits must be untouched.
        do_cfg(M_CTR, K_W, IV_W, err);
        ein_q.delete();
        send(128'h0, 1'b0);
        send(128'h0, 1'b1);
        recv(d, l);
        chk("wrap_c1", d, IV_W ^ K_W);
        recv(d, l);
        chk("wrap_c2", d, IV_W2 ^ K_W);
        chk("wrap_ein2", ein_at(1), IV_W2);

        // Backpressure: result held, FIFO fills, load rejected.
        do_cfg(M_ECB, K_BP, '0, err);
        send(128'h1, 1'b0);
        wait_mv();
        chk("bp_a_data", m_data, 128'h1 ^ K_BP);
        send(128'h2, 1'b0);
        chk("bp_ready_1", 128'(s_ready), 128'd1);
        send(128'h3, 1'b1);
        chk("bp_ready_full", 128'(s_ready), 128'd0);
        repeat (20) @(negedge clk);
        chk("bp_busy", 128'(busy), 128'd1);
        do_cfg(M_CBC, K_N, IV_CBC, err);
        chk("busy_cfg_err", 128'(err), 128'd1);
        chk("bp_a_held", m_data, 128'h1 ^ K_BP);
        recv(d, l);
        chk("bp_out_a", d, 128'h1 ^ K_BP);
        recv(d, l);
        chk("bp_out_b", d, 128'h2 ^ K_BP);
        recv(d, l);
        chk("bp_out_c", d, 128'h3 ^ K_BP);
        chk("bp_out_c_last", 128'(l), 128'd1);
        chk("hold_stable", 128'(n_hold), 128'd0);
        chk("start_in_hold", 128'(n_viol), 128'd0);
        chk("start_double", 128'(n_dbl), 128'd0);

        // Asynchronous reset while the engine is running.
        do_cfg(M_ECB, K_ECB, '0, err);
        ein_q.delete();
        send(P_ECB, 1'b0);
        n = 0;
        while (ein_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("run_started", 128'(ein_q.size()), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ctl",
            128'({s_ready, busy, m_valid, m_last, eng_start, cfg_err}),
            128'd0);
        chk("arst_eng_in", eng_in, 128'd0);
        chk("arst_eng_key", eng_key, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_s_ready", 128'(s_ready), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        do_cfg(M_ECB, K_ECB, '0, err);
        send(P_ECB, 1'b1);
        recv(d, l);
        chk("arst_recover", d, C_ECB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Streaming block-cipher mode controller that drives the team's 128-bit iterative AES encrypt engine (start/ready/valid engine interface) and adds ECB, CBC-encrypt and CTR modes.
- Adds a buffered valid/ready stream interface and message framing; the original engine offers single-shot ECB only.
- Sits between the bus/DMA-side data path and the engine; the engine ports connect one-to-one to the engine instance at integration.

Parameters:
- IN_DEPTH, 2: input FIFO depth in 128-bit blocks; power of two, >= 2.
- CTR_W, 32: width of the incrementing low part of the CTR counter block; 8..128.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved.
- cfg_key  in  128  key.
- cfg_iv  in  128  IV (CBC) or initial counter block (CTR).
- cfg_load  in  1  one-cycle pulse; latches mode, key and IV.
- cfg_err  out  1  one-cycle pulse; the load was rejected.
- busy  out  1  FIFO non-empty, or FSM not IDLE.
- s_valid  in  1  input block valid.
- s_ready  out  1  input can accept a block.
- s_data  in  128  plaintext block.
- s_last  in  1  last block of the message.
- m_valid  out  1  output block valid.
- m_ready  in  1  downstream accepts the block.
- m_data  out  128  ciphertext block.
- m_last  out  1  copy of s_last for this block.
- eng_start  out  1  one-cycle engine start pulse.
- eng_ready  in  1  engine idle.
- eng_valid  in  1  one-cycle pulse; eng_out is valid.
- eng_in  out  128  engine input block, registered.
- eng_key  out  128  key register.
- eng_out  in  128  engine result.

Behaviour:
- Reset (rst=0, async): all outputs 0; FIFO empty; FSM=IDLE; registers key_reg, iv_reg, chain, ctr and cfg_ok cleared.
- Configuration load (cfg_load=1):
  - Accepted only when busy=0, m_valid=0 and cfg_mode!=3.
  - On accept: latch key_reg, mode_reg, iv_reg; chain<=cfg_iv; ctr<=cfg_iv; cfg_ok<=1.
  - Otherwise: cfg_err=1 for one cycle next cycle; no state changes.
- Input side:
  - s_ready = cfg_ok & !fifo_full.
  - A push occurs when s_valid & s_ready; {s_data, s_last} is stored.
  - Push and pop in the same cycle are legal on a full FIFO; that cycle's s_ready still reflects full=1.
- FSM states:
  - IDLE -> START when FIFO non-empty, eng_ready=1 and m_valid=0.
    - Pop the head block into p_reg and last_reg.
    - Register eng_in per mode: ECB = P; CBC = P^chain; CTR = ctr.
  - START: eng_start=1 for exactly one cycle -> RUN.
  - RUN: wait for eng_valid.
    - Compute m_data: ECB/CBC = eng_out; CTR = p_reg^eng_out.
    - Set m_valid=1 and m_last=last_reg -> HOLD.
    - CBC: chain<=eng_out.
    - CTR: ctr[CTR_W-1:0] increments mod 2^CTR_W; upper 128-CTR_W bits unchanged; wrap gives no flag.
  - HOLD: m_valid and m_data stay stable until m_ready. On the handshake: m_valid<=0 -> IDLE.
    - If m_last=1, also chain<=iv_reg and ctr<=iv_reg (next message restarts from the IV).
- eng_valid outside RUN is ignored.
- Throughput: one block per (engine latency + 3) cycles when m_ready is held at 1.
- m_valid may not drop without a handshake.
- Reset mid-operation aborts: the in-flight block and FIFO contents are lost, and cfg_ok=0 (a reload is required).

Test Plan:
- ECB: key 000102030405060708090a0b0c0d0e0f, P 00112233445566778899aabbccddeeff -> m_data 69c4e0d86a7b0430d8cdb78070b4c55a; eng_start is a single pulse.
- CBC (SP800-38A F.2.1): key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102..0f.
  - P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
  - After P2 with s_last=1, resend P1 -> 7649abac... again.
- CTR (F.5.1): same key, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff.
  - P1 6bc1bee2... -> 874d6191b620e3261bef6864990db6ce.
  - Second eng_in = f0f1...fcfdff00 (CTR_W=32 wrap test uses IV low word ffffffff -> next eng_in low word 00000000, upper 96 bits unchanged).
- Backpressure: m_ready=0 for 20 cycles with IN_DEPTH=2.
  - s_ready drops after 2 more pushes.
  - m_data is stable throughout.
  - No eng_start occurs while m_valid=1.
  - Blocks drain in order once m_ready=1.
- Config errors:
  - cfg_load with cfg_mode=3 -> cfg_err pulse; mode unchanged.
  - cfg_load while busy -> cfg_err; the in-flight result is unchanged.
  - s_ready=0 before the first valid load.
- Reset mid-RUN: assert rst=0 asynchronously -> all outputs 0 immediately; s_ready stays 0 until a new cfg_load.
